// File: rtl/lab_nios_system_de2_pio_keys_debounced.sv
// Avalon-MM input PIO for DE2 keys/switches: two-flop synchroniser, per-bit
// debounce lanes, press edge-capture (W1C) and a maskable level interrupt.

module lab_nios_system_de2_pio_keys_debounced_lane #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_i,
  output logic stable_o,
  output logic press_o
);
  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_o  = 1'b0;
    if (sync_i == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      // disagreement held long enough: accept it, flag only presses
      stable_d = sync_i;
      cnt_d    = '0;
      press_o  = (sync_i != IDLE_LEVEL);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      stable_q <= IDLE_LEVEL;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
endmodule

module lab_nios_system_de2_pio_keys_debounced #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_RAW  = 2'd2;
  localparam logic [1:0] A_EDGE = 2'd3;

  typedef struct packed {
    logic [1:0]       addr;
    logic             wr;
    logic [WIDTH-1:0] wdata;
  } av_req_t;

  av_req_t          req;
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] mask_q,  mask_d;
  logic [WIDTH-1:0] cap_q,   cap_d;
  logic [WIDTH-1:0] stable_w;
  logic [WIDTH-1:0] press_w;
  logic             unused_wdata;

  assign req.addr     = address;
  assign req.wr       = chipselect & ~write_n;
  assign req.wdata    = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    lab_nios_system_de2_pio_keys_debounced_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (IDLE_LEVEL)
    ) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .sync_i   (sync2_q[i]),
      .stable_o (stable_w[i]),
      .press_o  (press_w[i])
    );
  end

  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
    mask_d  = mask_q;
    cap_d   = cap_q | press_w;
    if (req.wr && req.addr == A_MASK) mask_d = req.wdata;
    // a press landing on the same edge as its clear must survive
    if (req.wr && req.addr == A_EDGE) cap_d = (cap_q & ~req.wdata) | press_w;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= {WIDTH{IDLE_LEVEL}};
      sync2_q <= {WIDTH{IDLE_LEVEL}};
      mask_q  <= '0;
      cap_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (req.addr)
      A_DATA:  readdata[WIDTH-1:0] = stable_w;
      A_MASK:  readdata[WIDTH-1:0] = mask_q;
      A_RAW:   readdata[WIDTH-1:0] = sync2_q;
      default: readdata[WIDTH-1:0] = cap_q;
    endcase
  end

  assign irq = |(cap_q & mask_q);
endmodule

// File: tb/tb_lab_nios_system_de2_pio_keys_debounced.sv
// Directed bench for the debounced key PIO with an 8-cycle debounce window.

module tb_lab_nios_system_de2_pio_keys_debounced;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  lab_nios_system_de2_pio_keys_debounced #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (8),
    .IDLE_LEVEL      (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    chk(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  // write lands on the next rising edge
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_port    = 4'hF;

    // 1: reset values
    step(2);
    chk_reg("rst_data_in_reset", 2'd0, 32'h0000_000F);
    reset_n = 1'b1;
    step(1);
    chk_reg("rst_data", 2'd0, 32'h0000_000F);
    chk_reg("rst_mask", 2'd1, 32'h0);
    chk_reg("rst_raw",  2'd2, 32'h0000_000F);
    chk_reg("rst_edge", 2'd3, 32'h0);
    chk_irq("rst_irq", 1'b0);

    // 2: single press, latency DEBOUNCE+2 edges
    wr(2'd1, 32'h1);
    chk_reg("mask_wr", 2'd1, 32'h1);
    in_port = 4'hE;
    step(2);
    chk_reg("p2_raw_e1", 2'd2, 32'hE);
    step(7);
    chk_reg("p2_data_e8", 2'd0, 32'hF);
    chk_reg("p2_edge_e8", 2'd3, 32'h0);
    chk_irq("p2_irq_e8", 1'b0);
    step(1);
    chk_reg("p2_data_e9", 2'd0, 32'hE);
    chk_reg("p2_edge_e9", 2'd3, 32'h1);
    chk_irq("p2_irq_e9", 1'b1);

    // 3: 7-cycle bounce on bit 1 is rejected
    in_port = 4'hC;
    step(7);
    in_port = 4'hE;
    step(12);
    chk_reg("p3_bounce_data", 2'd0, 32'hE);
    chk_reg("p3_bounce_edge", 2'd3, 32'h1);
    chk_irq("p3_bounce_irq", 1'b1);
    in_port = 4'hC;
    step(9);
    chk_reg("p3_hold_e8", 2'd3, 32'h1);
    step(1);
    chk_reg("p3_hold_data", 2'd0, 32'hC);
    chk_reg("p3_hold_edge", 2'd3, 32'h3);

    // 4: W1C and mask interplay
    wr(2'd1, 32'h2);
    chk_irq("p4_irq_mask2", 1'b1);
    wr(2'd3, 32'h2);
    chk_reg("p4_edge_w1c", 2'd3, 32'h1);
    chk_irq("p4_irq_cleared", 1'b0);
    wr(2'd1, 32'h1);
    chk_irq("p4_irq_remask", 1'b1);

    // 5: release bit 0 (no capture), then clear collides with new press
    in_port = 4'hD;
    step(12);
    chk_reg("p5_rel_data", 2'd0, 32'hD);
    chk_reg("p5_rel_edge", 2'd3, 32'h1);
    in_port = 4'hC;
    step(9);
    wr(2'd3, 32'h1);
    chk_reg("p5_set_wins_data", 2'd0, 32'hC);
    chk_reg("p5_set_wins_edge", 2'd3, 32'h1);
    chk_irq("p5_set_wins_irq", 1'b1);
    wr(2'd3, 32'h1);
    chk_reg("p5_clear_edge", 2'd3, 32'h0);
    chk_irq("p5_clear_irq", 1'b0);

    // 6: reset with bit 2 half counted (cnt=4)
    in_port = 4'h8;
    step(6);
    reset_n = 1'b0;
    #1;
    chk_reg("p6_rst_data", 2'd0, 32'hF);
    chk_reg("p6_rst_raw",  2'd2, 32'hF);
    chk_reg("p6_rst_mask", 2'd1, 32'h0);
    chk_reg("p6_rst_edge", 2'd3, 32'h0);
    chk_irq("p6_rst_irq", 1'b0);
    step(2);
    reset_n = 1'b1;
    wr(2'd1, 32'hF);
    step(8);
    chk_reg("p6_e9_data", 2'd0, 32'hF);
    chk_reg("p6_e9_edge", 2'd3, 32'h0);
    chk_irq("p6_e9_irq", 1'b0);
    step(1);
    chk_reg("p6_e10_data", 2'd0, 32'h8);
    chk_reg("p6_e10_edge", 2'd3, 32'h7);
    chk_irq("p6_e10_irq", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
